fir_result_buffer: RTL and testbench
====================================

// Module: fir_result_buffer
// PURPOSE
//   Stage directly downstream of the 3-tap FIR filter. Captures each qualified 9-bit
//   FIR output into a FIFO and hands it to the pattern/host side over a valid/ready
//   handshake. Also keeps per-frame statistics (sum, sample count), closing each
//   frame on the FIR done pulse.
// PARAMETERS
//   DATA_W  9   FIR sample width
//   DEPTH   8   FIFO entries; power of 2, >= 2
//   ACC_W   16  frame_sum width; saturating
// PORTS
//   clk          in   1                 clock; all logic on posedge
//   rst          in   1                 reset, asynchronous, active-high
//   in_valid     in   1                 in_data holds a valid FIR output this cycle
//   in_data      in   DATA_W            FIR output sample
//   frame_end    in   1                 FIR done pulse; closes the current frame
//   out_valid    out  1                 FIFO head valid (= !empty)
//   out_ready    in   1                 consumer accepts head this cycle
//   out_data     out  DATA_W            FIFO head, first-word fall-through
//   full         out  1                 count == DEPTH
//   empty        out  1                 count == 0
//   count        out  $clog2(DEPTH)+1   current occupancy
//   overflow     out  1                 sticky; a sample was dropped
//   frame_sum    out  ACC_W             sum of the last closed frame
//   frame_cnt    out  8                 accepted samples in the last closed frame; saturates at 255
//   frame_valid  out  1                 1-cycle pulse when frame_sum/frame_cnt update
// BEHAVIOUR
//   Reset (async): pointers=0, count=0, empty=1, full=0, out_valid=0, out_data=0,
//     overflow=0, frame_sum=0, frame_cnt=0, frame_valid=0, FSM=IDLE, accumulators=0.
//     rst mid-frame discards the FIFO contents and the partial frame.
//   push = in_valid && (!full || pop); pop = out_valid && out_ready.
//   Write latency 1: a sample pushed in cycle N is at out_data in cycle N+1 if the FIFO was empty.
//   Empty + in_valid + out_ready: no pop that cycle; the sample appears next cycle.
//   Full + push + pop in the same cycle: both take effect; count stays DEPTH; no overflow.
//   Full + in_valid, no pop: sample dropped; overflow<=1 until rst.
//   Pointers wrap modulo DEPTH; out_data comes combinationally from mem[rd_ptr].
//   "Accepted" = push asserted. Dropped samples never enter the statistics.
//   Frame FSM:
//     IDLE   accepted sample -> ACCUM (acc=sample, n=1); frame_end alone is ignored.
//     ACCUM  accepted sample: acc+=sample (saturates at 2^ACC_W-1), n+=1 (saturates at 255).
//            frame_end -> FLUSH. A sample accepted in the same cycle is included in the frame.
//     FLUSH  frame_sum<=acc, frame_cnt<=n, frame_valid=1 for this cycle only.
//            An accepted sample here starts a new frame (-> ACCUM, acc=sample, n=1).
//            Otherwise -> IDLE, acc=0, n=0.
//   Arithmetic is unsigned; in_data is zero-extended to ACC_W before the add.
// CONFIGURATION
//   PEAK_TRACK_EN defined:
//     adds port frame_peak (out, DATA_W, reset 0) = max accepted sample of the last
//     closed frame; latched in FLUSH together with frame_sum. Running peak restarts
//     with the first sample of each frame.
//   PEAK_TRACK_EN undefined:
//     no frame_peak port and no peak logic; all other behaviour identical.
// TESTING
//   1 Push 5,6,7 then assert rst asynchronously mid-cycle -> empty=1, count=0,
//     out_valid=0, overflow=0 immediately, before the next clk edge.
//   2 out_ready=0; push 1..8 -> full=1, count=8; push 9 -> dropped, overflow=1;
//     out_ready=1 -> out_data reads 1..8 in order, then empty=1; overflow stays 1.
//   3 FIFO full with 1..8; in_valid=1, in_data=20, out_ready=1 in the same cycle ->
//     count stays 8, overflow=0; 20 is the last word read out.
//   4 Accept 30,47,86; then sample 3 with frame_end in the same cycle -> one cycle later
//     frame_valid=1 for exactly one cycle, frame_sum=166, frame_cnt=4,
//     frame_peak=86 (PEAK_TRACK_EN only).
//   5 ACC_W=10; one frame of 511,511,511 then frame_end -> frame_sum=1023 (saturated),
//     frame_cnt=3.
//   6 frame_end while IDLE with no samples -> frame_valid stays 0; frame_sum/frame_cnt unchanged.

Source files
------------

// File: rtl/fir_result_buffer_if.sv
// Sample stream and frame-control bundle between the FIR, the result buffer and its consumer.
interface fir_result_buffer_if #(
  parameter int DATA_W = 9
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              frame_end;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, frame_end, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, frame_end, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_result_buffer.sv
// FIR result FIFO (first-word fall-through) with per-frame sum/count statistics.
// Optional macro PEAK_TRACK_EN adds the frame_peak output (max sample of last closed frame).
module fir_result_buffer #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fir_result_buffer_if.slave         bus,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [ACC_W-1:0]           frame_sum,
  output logic [7:0]                 frame_cnt,
  output logic                       frame_valid
`ifdef PEAK_TRACK_EN
  ,output logic [DATA_W-1:0]         frame_peak
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push, pop;

  state_t            state;
  logic [ACC_W-1:0]  acc, acc_upd;
  logic [7:0]        n, n_upd;
`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] peak, peak_upd;
`endif

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(d);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty         = (cnt == '0);
  assign full          = (cnt == CW'(DEPTH));
  assign count         = cnt;
  assign bus.out_valid = !empty;
  // Gate the head with empty so the unreset storage never shows through.
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];

  assign pop  = !empty && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);

  // FIFO storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (bus.in_valid && !push) overflow <= 1'b1;
    end
  end

  assign acc_upd = push ? sat_add(acc, bus.in_data) : acc;
  assign n_upd   = push ? sat_inc(n) : n;
`ifdef PEAK_TRACK_EN
  assign peak_upd = (push && bus.in_data > peak) ? bus.in_data : peak;
`endif

  // Frame statistics FSM; results are registered on entry to FLUSH so they align with frame_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      n           <= '0;
      frame_sum   <= '0;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
`ifdef PEAK_TRACK_EN
      peak        <= '0;
      frame_peak  <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE, FLUSH: begin
          if (push) begin
            state <= ACCUM;
            acc   <= ACC_W'(bus.in_data);
            n     <= 8'd1;
`ifdef PEAK_TRACK_EN
            peak  <= bus.in_data;
`endif
          end else begin
            state <= IDLE;
            acc   <= '0;
            n     <= '0;
          end
        end
        ACCUM: begin
          if (bus.frame_end) begin
            state       <= FLUSH;
            frame_sum   <= acc_upd;
            frame_cnt   <= n_upd;
            frame_valid <= 1'b1;
            acc         <= '0;
            n           <= '0;
`ifdef PEAK_TRACK_EN
            frame_peak  <= peak_upd;
`endif
          end else begin
            acc  <= acc_upd;
            n    <= n_upd;
`ifdef PEAK_TRACK_EN
            peak <= peak_upd;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_result_buffer.sv
// Bench for fir_result_buffer: directed scenarios plus random traffic against a queue-based model,
// driving a default instance and an ACC_W=10 instance with identical stimulus.
module tb_fir_result_buffer;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_result_buffer_if #(.DATA_W(DATA_W)) if_a ();
  fir_result_buffer_if #(.DATA_W(DATA_W)) if_b ();

  assign if_b.in_valid  = if_a.in_valid;
  assign if_b.in_data   = if_a.in_data;
  assign if_b.frame_end = if_a.frame_end;
  assign if_b.out_ready = if_a.out_ready;

  logic        full_a, empty_a, ovf_a, fvld_a;
  logic [3:0]  count_a;
  logic [15:0] fsum_a;
  logic [7:0]  fcnt_a;
  logic        full_b, empty_b, ovf_b, fvld_b;
  logic [3:0]  count_b;
  logic [9:0]  fsum_b;
  logic [7:0]  fcnt_b;
`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] fpeak_a, fpeak_b;
`endif

  fir_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave),
    .full(full_a), .empty(empty_a), .count(count_a), .overflow(ovf_a),
    .frame_sum(fsum_a), .frame_cnt(fcnt_a), .frame_valid(fvld_a)
`ifdef PEAK_TRACK_EN
    , .frame_peak(fpeak_a)
`endif
  );

  fir_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(10)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave),
    .full(full_b), .empty(empty_b), .count(count_b), .overflow(ovf_b),
    .frame_sum(fsum_b), .frame_cnt(fcnt_b), .frame_valid(fvld_b)
`ifdef PEAK_TRACK_EN
    , .frame_peak(fpeak_b)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO as a queue, frame as an unbounded running total clamped on close.
  int q[$];
  int m_ovf;
  int open, run_sum, run_n, run_peak;
  int e_valid, e_sum, e_n, e_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; open = 0; run_sum = 0; run_n = 0; run_peak = 0;
    e_valid = 0; e_sum = 0; e_n = 0; e_peak = 0;
  endtask

  task automatic check_all();
    int hd;
    hd = (q.size() > 0) ? q[0] : 0;
    chk("out_valid", if_a.out_valid, (q.size() > 0));
    chk("out_data",  if_a.out_data,  hd);
    chk("count",     count_a,        q.size());
    chk("full",      full_a,         (q.size() == DEPTH));
    chk("empty",     empty_a,        (q.size() == 0));
    chk("overflow",  ovf_a,          m_ovf);
    chk("frame_valid", fvld_a,       e_valid);
    chk("frame_sum",   fsum_a,       clamp(e_sum, 65535));
    chk("frame_cnt",   fcnt_a,       clamp(e_n, 255));
    chk("b_out_data",  if_b.out_data, hd);
    chk("b_count",     count_b,       q.size());
    chk("b_frame_valid", fvld_b,      e_valid);
    chk("b_frame_sum",   fsum_b,      clamp(e_sum, 1023));
    chk("b_frame_cnt",   fcnt_b,      clamp(e_n, 255));
`ifdef PEAK_TRACK_EN
    chk("frame_peak",   fpeak_a, e_peak);
    chk("b_frame_peak", fpeak_b, e_peak);
`endif
  endtask

  task automatic model_step(input int iv, input int d, input int rdy, input int fe);
    int do_pop, do_push, closing;
    do_pop  = (q.size() > 0) && rdy;
    do_push = iv && ((q.size() < DEPTH) || do_pop);
    closing = open && fe;
    if (iv && !do_push) m_ovf = 1;
    if (do_push) begin
      if (open) begin
        run_sum += d; run_n++;
        if (d > run_peak) run_peak = d;
      end else begin
        open = 1; run_sum = d; run_n = 1; run_peak = d;
      end
    end
    e_valid = closing;
    if (closing) begin
      e_sum = run_sum; e_n = run_n; e_peak = run_peak;
      open = 0;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
  endtask

  // Called 1 time unit after a rising edge: drive, check current outputs, advance model, clock.
  task automatic step(input int iv, input int d, input int rdy, input int fe);
    if_a.in_valid  = iv[0];
    if_a.in_data   = d[DATA_W-1:0];
    if_a.out_ready = rdy[0];
    if_a.frame_end = fe[0];
    #1;
    check_all();
    model_step(iv, d, rdy, fe);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_a.in_valid = 1'b0; if_a.frame_end = 1'b0; if_a.out_ready = 1'b0; if_a.in_data = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_empty",     empty_a,        1);
    chk("rst_count",     count_a,        0);
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_overflow",  ovf_a,          0);
    chk("rst_out_data",  if_a.out_data,  0);
    chk("rst_frame_sum", fsum_a,         0);
    chk("rst_frame_cnt", fcnt_a,         0);
    chk("rst_frame_valid", fvld_a,       0);
    model_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.frame_end = 1'b0; if_a.out_ready = 1'b0;
    model_reset();
    #1;
    do_reset();

    // 1: async reset mid-frame with data in flight
    step(1, 5, 0, 0); step(1, 6, 0, 0); step(1, 7, 0, 0);
    chk("t1_count_before_rst", count_a, 3);
    do_reset();

    // 2: fill, drop on full, drain in order
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0);
    chk("t2_full",  full_a,  1);
    chk("t2_count", count_a, 8);
    step(1, 9, 0, 0);
    chk("t2_overflow", ovf_a, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain_order", if_a.out_data, i);
      step(0, 0, 1, 0);
    end
    chk("t2_empty_after", empty_a, 1);
    chk("t2_overflow_sticky", ovf_a, 1);
    do_reset();

    // 3: simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0);
    step(1, 20, 1, 0);
    chk("t3_count_stays", count_a, 8);
    chk("t3_no_overflow", ovf_a, 0);
    for (int i = 2; i <= 8; i++) step(0, 0, 1, 0);
    chk("t3_last_word", if_a.out_data, 20);
    step(0, 0, 1, 0);
    chk("t3_empty", empty_a, 1);
    do_reset();

    // 4: frame closed with a sample in the same cycle
    step(1, 30, 1, 0); step(1, 47, 1, 0); step(1, 86, 1, 0); step(1, 3, 1, 1);
    chk("t4_frame_valid", fvld_a, 1);
    chk("t4_frame_sum", fsum_a, 166);
    chk("t4_frame_cnt", fcnt_a, 4);
`ifdef PEAK_TRACK_EN
    chk("t4_frame_peak", fpeak_a, 86);
`endif
    step(0, 0, 1, 0);
    chk("t4_pulse_one_cycle", fvld_a, 0);

    // 6: frame_end while idle is ignored
    step(0, 0, 1, 1); step(0, 0, 1, 0);
    chk("t6_no_pulse", fvld_a, 0);
    chk("t6_sum_held", fsum_a, 166);
    chk("t6_cnt_held", fcnt_a, 4);

    // 5: saturation in the ACC_W=10 instance
    step(1, 511, 1, 0); step(1, 511, 1, 0); step(1, 511, 1, 0); step(0, 0, 1, 1);
    chk("t5_b_sum_sat", fsum_b, 1023);
    chk("t5_b_cnt", fcnt_b, 3);
    chk("t5_a_sum", fsum_a, 1533);

    // Sample-count saturation at 255
    for (int i = 0; i < 300; i++) step(1, $urandom_range(511, 0), 1, 0);
    step(0, 0, 1, 1);
    chk("cnt_sat", fcnt_a, 255);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(9, 0) < 7), $urandom_range(511, 0),
           ($urandom_range(1, 0)), ($urandom_range(9, 0) == 0));
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
